// File: rtl/wrr_burst_arb_if.sv
// Bus bundle for wrr_burst_arb: NumIn upstream valid/ready channels in, one registered channel out.
interface wrr_burst_arb_if #(
    parameter int unsigned NumIn       = 4,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned WeightWidth = 4
);
    localparam int unsigned IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1;

    logic [NumIn-1:0][WeightWidth-1:0] weight_i;
    logic [NumIn-1:0]                  valid_i;
    logic [NumIn-1:0]                  ready_o;
    logic [NumIn-1:0][DataWidth-1:0]   data_i;
    logic                              valid_o;
    logic                              ready_i;
    logic [DataWidth-1:0]              data_o;
    logic [IdxWidth-1:0]               idx_o;

    modport slave (
        input  weight_i, valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, idx_o
    );

    modport master (
        output weight_i, valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, idx_o
    );
endinterface

// File: rtl/wrr_burst_arb.sv
// Weighted round-robin burst arbiter: a winner keeps the channel for up to w_eff beats,
// then priority rotates. Output is a one-entry registered stage with full throughput.
module wrr_burst_arb #(
    parameter int unsigned NumIn       = 4,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned WeightWidth = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    wrr_burst_arb_if.slave        bus
);
    localparam int unsigned IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [IdxWidth-1:0]    ptr_q, ptr_d;
    logic [IdxWidth-1:0]    cur_q, cur_d;
    logic [WeightWidth-1:0] credit_q, credit_d;
    logic                   valid_q, valid_d;
    logic [DataWidth-1:0]   data_q, data_d;
    logic [IdxWidth-1:0]    idx_q, idx_d;

    logic                   can_acc;
    logic                   any_valid;
    logic [IdxWidth-1:0]    winner;
    logic [IdxWidth-1:0]    hs_idx;
    logic                   hs;
    logic [NumIn-1:0]       ready_c;
    logic [WeightWidth-1:0] w_sel;
    logic [WeightWidth-1:0] w_eff;
    int unsigned            scan;

    function automatic logic [IdxWidth-1:0] next_idx(input logic [IdxWidth-1:0] k);
        return (32'(k) >= NumIn - 1) ? '0 : IdxWidth'(32'(k) + 32'd1);
    endfunction

    // Rotating priority scan starting at ptr_q.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        scan      = 0;
        for (int unsigned i = 0; i < NumIn; i++) begin
            scan = 32'(ptr_q) + i;
            if (scan >= NumIn) scan = scan - NumIn;
            if (!any_valid && bus.valid_i[IdxWidth'(scan)]) begin
                any_valid = 1'b1;
                winner    = IdxWidth'(scan);
            end
        end
    end

    assign w_sel = bus.weight_i[winner];
    assign w_eff = (w_sel == '0) ? WeightWidth'(1) : w_sel;

    // Grant, output stage and burst FSM next-state.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cur_d    = cur_q;
        credit_d = credit_q;
        valid_d  = valid_q;
        data_d   = data_q;
        idx_d    = idx_q;
        ready_c  = '0;
        can_acc  = ~valid_q | bus.ready_i;
        hs_idx   = (state_q == BURST) ? cur_q : winner;

        if (NumIn == 1) begin
            ready_c[0] = can_acc;
            hs_idx     = '0;
        end else if (state_q == IDLE) begin
            if (any_valid) ready_c[winner] = can_acc;
        end else begin
            ready_c[cur_q] = can_acc;
        end
        if (flush_i) ready_c = '0;

        hs = |(bus.valid_i & ready_c);

        if (hs) begin
            valid_d = 1'b1;
            data_d  = bus.data_i[hs_idx];
            idx_d   = hs_idx;
        end else if (bus.ready_i) begin
            valid_d = 1'b0;
        end

        if (NumIn > 1) begin
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        if (w_eff == WeightWidth'(1)) begin
                            ptr_d = next_idx(winner);
                        end else begin
                            state_d  = BURST;
                            cur_d    = winner;
                            credit_d = w_eff - 1'b1;
                        end
                    end
                end
                BURST: begin
                    // A dropped valid abandons the burst; leftover credit is forfeited.
                    if (!bus.valid_i[cur_q]) begin
                        state_d  = IDLE;
                        ptr_d    = next_idx(cur_q);
                        credit_d = '0;
                    end else if (hs) begin
                        credit_d = credit_q - 1'b1;
                        if (credit_q == WeightWidth'(1)) begin
                            state_d = IDLE;
                            ptr_d   = next_idx(cur_q);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (flush_i) begin
            state_d  = IDLE;
            ptr_d    = '0;
            cur_d    = '0;
            credit_d = '0;
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cur_q    <= '0;
            credit_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cur_q    <= cur_d;
            credit_q <= credit_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
        end
    end

    assign bus.ready_o = ready_c;
    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;
    assign bus.idx_o   = idx_q;
endmodule

// File: doc/wrr_burst_arb.md
Name: wrr_burst_arb

Overview:
- Weighted round-robin stream arbiter. Shares one downstream valid/ready channel (e.g. an FPU operation-group input or a shared memory port) between NumIn upstream requesters.
- A requester that wins keeps the channel for up to weight_i[k] consecutive beats, then priority rotates to k+1.
- The output is registered: one-entry pipeline stage, full throughput, 1-cycle latency.
- Counterpart to the per-cycle round-robin arbiter tree, for traffic that needs burst locality and configurable bandwidth shares.

Parameters:
- NumIn, 4, number of requesters (>=1).
- DataWidth, 32, payload width in bits.
- WeightWidth, 4, width of each per-requester weight; max burst = 2**WeightWidth-1.
- IdxWidth, (NumIn>1 ? $clog2(NumIn) : 1), width of index signals; derived, not overridable.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of arbitration state and output stage.
- weight_i  in  NumIn*WeightWidth  per-requester burst weight, packed [NumIn-1:0][WeightWidth-1:0]; 0 is treated as 1.
- valid_i  in  NumIn  upstream valid.
- ready_o  out  NumIn  upstream ready; at most one bit set.
- data_i  in  NumIn*DataWidth  upstream payload, packed [NumIn-1:0][DataWidth-1:0].
- valid_o  out  1  downstream valid (registered).
- ready_i  in  1  downstream ready.
- data_o  out  DataWidth  downstream payload (registered).
- idx_o  out  IdxWidth  source requester of the current data_o beat (registered).

Behaviour:
- Interface: one clock, clk_i. rst_ni is asynchronous, active-low.
- Reset values: valid_o=0, data_o=0, idx_o=0, state=IDLE, ptr_q=0, cur_q=0, credit_q=0. ready_o is combinational and reset-safe (0 while valid_o=0 and nothing is requesting).
- Output stage: can_acc = ~valid_o | ready_i.
  - An upstream handshake (valid_i[k] & ready_o[k]) loads data_o<=data_i[k], idx_o<=k, valid_o<=1.
  - valid_o clears on a downstream handshake with no new upstream handshake.
  - data_o/idx_o are stable while valid_o & ~ready_i (AXI rule). Latency input->output: 1 cycle.
- winner: first k with valid_i[k]=1, scanning ptr_q, ptr_q+1, ... modulo NumIn (wraps NumIn-1 -> 0). Pure combinational priority rotate; no dependence on ready_i except through can_acc.
- w_eff(k) = (weight_i[k]==0) ? 1 : weight_i[k]. Weight is sampled only when a burst starts; later weight_i changes do not affect the running burst.
- FSM IDLE:
  - ready_o[winner] = can_acc when any valid_i is set; all other ready_o = 0.
  - On handshake from k with w_eff(k)==1: stay IDLE, ptr_q<=k+1 (wrap).
  - On handshake from k with w_eff(k)>1: go BURST, cur_q<=k, credit_q<=w_eff(k)-1.
  - No handshake: no state change; the winner may change next cycle.
- FSM BURST:
  - ready_o[cur_q] = can_acc; all other ready_o = 0.
  - On handshake: credit_q-1. If credit_q==1 at the handshake: go IDLE, ptr_q<=cur_q+1.
  - If valid_i[cur_q]==0 in a cycle: abandon the burst, go IDLE, ptr_q<=cur_q+1, remaining credit discarded. This costs one bubble cycle by design.
  - Downstream backpressure (can_acc=0) holds state and credit indefinitely; other requesters are not served.
- Simultaneous events:
  - flush_i overrides everything: state=IDLE, ptr_q=0, credit_q=0, valid_o<=0, held beat discarded, no ready_o asserted that cycle.
  - An asserted rst_ni overrides flush_i.
  - A downstream and an upstream handshake in the same cycle sustain 1 beat/cycle.
- NumIn==1: FSM and weights ignored. ready_o[0]=can_acc, idx_o=0. Still a registered stage.
- Invariants (bench assertions):
  - $onehot0(ready_o).
  - ready_o[k] implies valid_i[k] in IDLE.
  - credit_q <= 2**WeightWidth-2.
  - valid_o & ~ready_i |=> $stable({data_o,idx_o}) & valid_o.
  - Starvation bound: a continuously valid requester is served within sum of other w_eff + NumIn cycles, given ready_i=1.

Test Plan:
- NumIn=4, all weights 1, all valid_i=1, ready_i=1 -> idx_o sequence 0,1,2,3,0,... one beat/cycle, first valid_o one cycle after the first accept.
- Weights {3,1,2,0}, all valid, ready_i=1 -> idx_o 0,0,0,1,2,2,3,0,0,0,... (weight 0 behaves as 1).
- Weight[0]=5, only requester 0 valid, valid_i[0] drops after 2 beats while valid_i[2]=1 -> one bubble cycle, then idx_o=2; ptr_q=1 before the requester 2 grant.
- ready_i held 0 for 4 cycles mid-burst (weight 3, after the 1st beat) -> valid_o=1 and data_o/idx_o frozen, ready_o all 0; after release, exactly 2 more beats from the same requester, then rotation.
- flush_i asserted mid-burst with valid_o=1 -> next cycle valid_o=0, ptr_q=0; with all valid_i set, next idx_o=0 regardless of the prior rotation.
- rst_ni pulsed low asynchronously mid-burst (between clock edges) -> valid_o=0 immediately; after release, arbitration restarts at requester 0 with fresh credit.
